// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the read (and later write) port arbiters.
package regfile_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_DEPTH      = 32;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any
);

    // Scan ptr, ptr+1, ... wrapping at NUM_REQ; ptr is always below NUM_REQ.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = ID_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register-file read port among NUM_REQ requesters with round-robin
// arbitration, an optional owner lock, and a registered, ID-tagged read return.
module regfile_read_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            lock,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [ADDR_WIDTH-1:0]         rf_addr,
    input  logic [DATA_WIDTH-1:0]         rf_data,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [ID_WIDTH-1:0]           rd_id
);

    arb_state_t            state, state_n;
    logic [ID_WIDTH-1:0]   owner, owner_n;
    logic [ID_WIDTH-1:0]   ptr, ptr_n;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [NUM_REQ-1:0]    pick_gnt;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  pick_any;
    logic [NUM_REQ-1:0]    one_hot_base;

    assign one_hot_base = {{(NUM_REQ-1){1'b0}}, 1'b1};

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + ID_WIDTH'(1);
    endfunction

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A dropped owner request releases the lock without granting anyone that cycle.
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        gnt     = '0;
        gnt_idx = '0;
        rf_addr = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt     = pick_gnt;
                        gnt_idx = pick_idx;
                        ptr_n   = next_id(pick_idx);
                        if (lock[pick_idx]) begin
                            state_n = LOCKED;
                            owner_n = pick_idx;
                        end
                    end
                end
                LOCKED: begin
                    if (req[owner]) begin
                        gnt     = one_hot_base << owner;
                        gnt_idx = owner;
                        ptr_n   = next_id(owner);
                        if (!lock[owner]) begin
                            state_n = IDLE;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (gnt != '0) begin
                rf_addr = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_id    <= '0;
        end else if (gnt != '0) begin
            rd_valid <= 1'b1;
            rd_data  <= rf_data;
            rd_id    <= gnt_idx;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a behavioural 32-entry register file.
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = '0;
    logic [19:0] req_addr = '0;
    logic [3:0]  lock = '0;
    logic [3:0]  gnt;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_id;

    logic [31:0] regs [32];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rf_data = regs[rf_addr];

    regfile_read_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .lock     (lock),
        .gnt      (gnt),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_id    (rd_id)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge, well away from the capture edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
        @(negedge clk);
        req  = r;
        lock = l;
        #1;
    endtask

    task automatic setAddr(input int i, input logic [4:0] a);
        req_addr[i*5 +: 5] = a;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
        regs[7] = 32'hDEADBEEF;
        setAddr(0, 5'd1);
        setAddr(1, 5'd2);
        setAddr(2, 5'd3);
        setAddr(3, 5'd4);

        // Reset with every requester asking.
        req = 4'b1111;
        #1 rst_n = 1'b0;
        #11;
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_valid", 32'(rd_valid), 32'h0);
        checkOutput("rst_data", rd_data, 32'h0);
        checkOutput("rst_id", 32'(rd_id), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("first_gnt", 32'(gnt), 32'h1);
        checkOutput("first_addr", 32'(rf_addr), 32'd1);

        applyStimulus(4'b0000, 4'b0000);
        checkOutput("first_valid", 32'(rd_valid), 32'h1);
        checkOutput("first_id", 32'(rd_id), 32'd0);
        checkOutput("first_data", rd_data, 32'hA000_0001);
        checkOutput("idle_gnt", 32'(gnt), 32'h0);
        checkOutput("idle_addr", 32'(rf_addr), 32'h0);

        // Single read of reg 7 by requester 2.
        setAddr(2, 5'd7);
        applyStimulus(4'b0100, 4'b0000);
        checkOutput("single_gnt", 32'(gnt), 32'h4);
        checkOutput("single_addr", 32'(rf_addr), 32'd7);
        checkOutput("single_prevalid", 32'(rd_valid), 32'h0);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("single_valid", 32'(rd_valid), 32'h1);
        checkOutput("single_data", rd_data, 32'hDEADBEEF);
        checkOutput("single_id", 32'(rd_id), 32'd2);
        setAddr(2, 5'd3);

        // ptr is 3; grant requester 3 so the pointer wraps to 0.
        applyStimulus(4'b1000, 4'b0000);
        checkOutput("wrap_gnt", 32'(gnt), 32'h8);

        // Full rotation with everybody requesting.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 4'b0000);
            checkOutput($sformatf("rot_gnt%0d", k), 32'(gnt), 32'h1 << (k % 4));
            checkOutput($sformatf("rot_addr%0d", k), 32'(rf_addr), 32'((k % 4) + 1));
            checkOutput($sformatf("rot_valid%0d", k), 32'(rd_valid), 32'h1);
            checkOutput($sformatf("rot_id%0d", k), 32'(rd_id), 32'((k + 3) % 4));
            checkOutput($sformatf("rot_data%0d", k), rd_data, 32'hA000_0000 + 32'(((k + 3) % 4) + 1));
        end

        // Move ptr to 1, then requester 1 locks for three cycles plus its release cycle.
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("pre_lock_gnt", 32'(gnt), 32'h1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0011, 4'b0010);
            checkOutput($sformatf("lock_gnt%0d", k), 32'(gnt), 32'h2);
        end
        applyStimulus(4'b0011, 4'b0000);
        checkOutput("unlock_gnt", 32'(gnt), 32'h2);
        applyStimulus(4'b0011, 4'b0000);
        checkOutput("after_lock_gnt", 32'(gnt), 32'h1);
        checkOutput("after_lock_id", 32'(rd_id), 32'd1);

        // Owner drops its request while locked.
        applyStimulus(4'b0010, 4'b0010);
        checkOutput("own_gnt", 32'(gnt), 32'h2);
        applyStimulus(4'b1010, 4'b0010);
        checkOutput("own_ignore_gnt", 32'(gnt), 32'h2);
        applyStimulus(4'b1000, 4'b0010);
        checkOutput("drop_gnt", 32'(gnt), 32'h0);
        checkOutput("drop_addr", 32'(rf_addr), 32'h0);
        applyStimulus(4'b1000, 4'b0000);
        checkOutput("drop_valid", 32'(rd_valid), 32'h0);
        checkOutput("wait3_gnt", 32'(gnt), 32'h8);

        // A lone requester is granted every cycle.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0100, 4'b0000);
            checkOutput($sformatf("solo_gnt%0d", k), 32'(gnt), 32'h4);
        end

        // Reset between the grant and its capture edge.
        #2 rst_n = 1'b0;
        req = 4'b1111;
        #1;
        checkOutput("midrst_gnt", 32'(gnt), 32'h0);
        checkOutput("midrst_valid", 32'(rd_valid), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("midrst_edge_valid", 32'(rd_valid), 32'h0);
        checkOutput("midrst_data", rd_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("postrst_gnt", 32'(gnt), 32'h1);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("postrst_valid", 32'(rd_valid), 32'h1);
        checkOutput("postrst_id", 32'(rd_id), 32'd0);
        checkOutput("postrst_data", rd_data, 32'hA000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
